slot_scatter: RTL and testbench

Write-side counterpart of the register-datapath priority select chain: where the select chain gathers the value of the first asserting source, this block scatters an incoming 32-bit value into the first free entry of a small slot bank. It accepts a valid/ready word stream, deposits each accepted word in the lowest-index empty slot, and holds it until a consumer releases it. It sits between the execute/writeback datapath and the downstream consumers that read `slot_data` in parallel.

---
 rtl/csrisc_pkg.sv | 12 +
 rtl/alloc_gadget.sv | 14 +
 rtl/slot_scatter.sv | 104 ++++++++++
 tb/tb_slot_scatter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csrisc_pkg.sv
// Shared datapath constants and index-width helpers for the csrisc slice.
package csrisc_pkg;
   localparam int WORD_W    = 32;
   localparam int NSLOT_DEF = 8;

   // Index width for an n-entry bank, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [$clog2(NSLOT_DEF)-1:0] slot_idx_t;
endpackage

// File: rtl/alloc_gadget.sv
// One link of the allocation priority chain: picks this slot if it is free
// and no lower-index slot has already been taken.
module alloc_gadget (
   input  logic c_in,
   input  logic free,
   output logic c_out,
   output logic sel
);
   // Propagate the taken flag upward and select only the first free slot.
   always_comb begin
      c_out = c_in | free;
      sel   = free & ~c_in;
   end
endmodule

// File: rtl/slot_scatter.sv
// Scatters an accepted word into the lowest-index empty slot of a small bank
// and holds it there until a consumer releases that slot.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (and rst_n); a release in the
// same cycle does not raise it. While in_ready is low the producer must hold
// in_valid and in_data stable; nothing is taken.
module slot_scatter
   import csrisc_pkg::*;
#(
   parameter int NSLOT = 8,
   parameter int W     = WORD_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [W-1:0]                 in_data,
   input  logic [NSLOT-1:0]             rel,
   output logic [NSLOT-1:0]             slot_valid,
   output logic [NSLOT*W-1:0]           slot_data,
   output logic                         wr_fire,
   output logic [idx_w(NSLOT)-1:0]      wr_idx,
   output logic [$clog2(NSLOT+1)-1:0]   count,
   output logic                         full,
   output logic                         err_rel
);
   localparam int IW = idx_w(NSLOT);
   localparam int CW = $clog2(NSLOT+1);

   logic [NSLOT:0]   carry;
   logic [NSLOT-1:0] sel;
   logic [NSLOT-1:0] wr_mask;
   logic [NSLOT-1:0] rel_hit;
   logic             rel_miss;
   logic             accept;
   logic [IW-1:0]    enc_idx;
   logic [CW-1:0]    count_nxt;

   assign carry[0] = 1'b0;

   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_chain
         alloc_gadget u_gadget (
            .c_in  (carry[gi]),
            .free  (~slot_valid[gi]),
            .c_out (carry[gi+1]),
            .sel   (sel[gi])
         );
      end
   endgenerate

   // Ready and accept decision; carry[NSLOT] confirms a free slot exists.
   always_comb begin
      full     = (count == CW'(NSLOT));
      in_ready = rst_n && !full;
      accept   = in_valid && in_ready && carry[NSLOT];
      wr_mask  = accept ? sel : '0;
      rel_hit  = rel & slot_valid;
      rel_miss = |(rel & ~slot_valid);
   end

   // One-hot select to binary slot index.
   always_comb begin
      enc_idx = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (sel[i]) enc_idx = IW'(i);
      end
   end

   // Live-slot count: accepts add one, valid releases subtract.
   always_comb begin
      count_nxt = count + CW'(accept) - CW'($countones(rel_hit));
   end

   // Slot occupancy, write report, count and sticky release error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         wr_fire    <= 1'b0;
         wr_idx     <= '0;
         count      <= '0;
         err_rel    <= 1'b0;
      end else begin
         slot_valid <= (slot_valid & ~rel_hit) | wr_mask;
         wr_fire    <= accept;
         if (accept) wr_idx <= enc_idx;
         count      <= count_nxt;
         if (rel_miss) err_rel <= 1'b1;
      end
   end

   // Slot payload storage; contents are kept after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_data <= '0;
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            if (wr_mask[i]) slot_data[i*W +: W] <= in_data;
         end
      end
   end
endmodule

// File: tb/tb_slot_scatter.sv
// Bench for slot_scatter: directed vector table, hand-written corner
// sequences and random traffic against a slot-bank model.
module tb_slot_scatter;
   import csrisc_pkg::*;

   localparam int NSLOT = 8;
   localparam int W     = 32;

   logic                 clk;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_data;
   logic [NSLOT-1:0]     rel;
   logic [NSLOT-1:0]     slot_valid;
   logic [NSLOT*W-1:0]   slot_data;
   logic                 wr_fire;
   logic [2:0]           wr_idx;
   logic [3:0]           count;
   logic                 full;
   logic                 err_rel;

   slot_scatter #(.NSLOT(NSLOT), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rel        (rel),
      .slot_valid (slot_valid),
      .slot_data  (slot_data),
      .wr_fire    (wr_fire),
      .wr_idx     (wr_idx),
      .count      (count),
      .full       (full),
      .err_rel    (err_rel)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // model of the slot bank
   bit          m_valid [NSLOT];
   logic [W-1:0] m_data [NSLOT];
   bit          m_err;
   bit          m_fire;
   int          m_idx;
   logic [W-1:0] exp_q [$];

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < NSLOT; i++) c += m_valid[i];
      return c;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < NSLOT; i++) begin
         m_valid[i] = 0;
         m_data[i]  = '0;
      end
      m_err  = 0;
      m_fire = 0;
      m_idx  = 0;
      exp_q.delete();
   endtask

   task automatic chk(input string name, input logic [NSLOT*W-1:0] act,
                      input logic [NSLOT*W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // compare every observable output against the model
   task automatic chk_all(input string tag);
      logic [NSLOT-1:0]   ev;
      logic [NSLOT*W-1:0] act_d, exp_d;
      ev = '0;
      act_d = '0;
      exp_d = '0;
      for (int i = 0; i < NSLOT; i++) begin
         ev[i] = m_valid[i];
         if (m_valid[i]) begin
            act_d[i*W +: W] = slot_data[i*W +: W];
            exp_d[i*W +: W] = m_data[i];
         end
      end
      chk({tag, ".slot_valid"}, slot_valid, ev);
      chk({tag, ".slot_data"}, act_d, exp_d);
      chk({tag, ".wr_fire"}, wr_fire, m_fire);
      chk({tag, ".wr_idx"}, wr_idx, m_idx);
      chk({tag, ".count"}, count, m_count());
      chk({tag, ".full"}, full, m_count() == NSLOT);
      chk({tag, ".in_ready"}, in_ready, m_count() < NSLOT);
      chk({tag, ".err_rel"}, err_rel, m_err);
      // scoreboard: each reported write must carry the oldest pending word
      if (wr_fire === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s.sb: write reported with nothing pending", tag);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (slot_data[wr_idx*W +: W] !== e) begin
               n_bad++;
               $display("FAIL %s.sb: got %0h, expected %0h", tag,
                        slot_data[wr_idx*W +: W], e);
            end
         end
      end
   endtask

   // driver: apply one cycle of stimulus, advance the model, check outputs
   task automatic step(input logic v, input logic [W-1:0] d,
                       input logic [NSLOT-1:0] r, input string tag);
      bit acc;
      int tgt;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      rel      = r;
      #1;
      chk({tag, ".pre_ready"}, in_ready, m_count() < NSLOT);
      acc = v && (m_count() < NSLOT);
      tgt = -1;
      for (int i = NSLOT-1; i >= 0; i--) if (!m_valid[i]) tgt = i;
      @(posedge clk);
      #1;
      for (int i = 0; i < NSLOT; i++) begin
         if (r[i]) begin
            if (m_valid[i]) m_valid[i] = 0;
            else m_err = 1;
         end
      end
      if (acc) begin
         m_valid[tgt] = 1;
         m_data[tgt]  = d;
         m_fire       = 1;
         m_idx        = tgt;
         exp_q.push_back(d);
      end else begin
         m_fire = 0;
      end
      chk_all(tag);
      in_valid = 1'b0;
      rel      = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic             v;
      logic [W-1:0]     d;
      logic [NSLOT-1:0] r;
      logic             e_fire;
      logic [2:0]       e_idx;
      logic [3:0]       e_count;
      logic             e_full;
      logic             e_err;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(logic v, logic [W-1:0] d, logic [NSLOT-1:0] r,
                               logic f, logic [2:0] ix, logic [3:0] c,
                               logic fu, logic er);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.e_fire = f; t.e_idx = ix;
      t.e_count = c; t.e_full = fu; t.e_err = er;
      return t;
   endfunction

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      rel      = '0;
      m_reset();

      // reset values while rst_n is low
      #12;
      chk("rst.slot_valid", slot_valid, '0);
      chk("rst.slot_data", slot_data, '0);
      chk("rst.outs", {wr_fire, wr_idx, count, full, err_rel, in_ready}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.ready_rise", in_ready, 1'b1);

      // directed table: fill, full hold, release 5, refill, empty-slot release
      tbl.push_back(mk(1, 32'hA, 8'h00, 1, 0, 1, 0, 0));
      tbl.push_back(mk(1, 32'hB, 8'h00, 1, 1, 2, 0, 0));
      tbl.push_back(mk(1, 32'hC, 8'h00, 1, 2, 3, 0, 0));
      for (int i = 3; i < NSLOT; i++)
         tbl.push_back(mk(1, 32'h10 + i, 8'h00, 1, 3'(i), 4'(i + 1), i == NSLOT-1, 0));
      tbl.push_back(mk(1, 32'hDD, 8'h00, 0, 7, 8, 1, 0));
      tbl.push_back(mk(1, 32'hDD, 8'h20, 0, 7, 7, 0, 0));
      tbl.push_back(mk(1, 32'hDD, 8'h00, 1, 5, 8, 1, 0));
      tbl.push_back(mk(0, 32'h0,  8'hC0, 0, 5, 6, 0, 0));
      tbl.push_back(mk(0, 32'h0,  8'h40, 0, 5, 6, 0, 1));
      tbl.push_back(mk(0, 32'h0,  8'h00, 0, 5, 6, 0, 1));
      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].v, tbl[k].d, tbl[k].r, $sformatf("tbl%0d", k));
         chk($sformatf("tbl%0d.vec", k), {wr_fire, wr_idx, count, full, err_rel},
             {tbl[k].e_fire, tbl[k].e_idx, tbl[k].e_count, tbl[k].e_full, tbl[k].e_err});
      end
      chk("tbl.slot0", slot_data[0 +: W], 32'hA);
      chk("tbl.slot5", slot_data[5*W +: W], 32'hDD);

      // same-cycle release of slot 1 and accept: word goes to slot 4
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 32'h100 + i, '0, "fill4");
      step(1, 32'h55, 8'h02, "relacc");
      chk("relacc.idx", wr_idx, 3'd4);
      chk("relacc.count", count, 4'd4);
      chk("relacc.valid", slot_valid, 8'b0001_1101);
      chk("relacc.data", slot_data[4*W +: W], 32'h55);

      // asynchronous reset mid-stream with 5 live slots
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 32'h200 + i, '0, "fill5");
      step(0, '0, 8'h80, "mkerr");
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      chk("arst.slot_valid", slot_valid, '0);
      chk("arst.slot_data", slot_data, '0);
      chk("arst.outs", {wr_fire, wr_idx, count, full, err_rel, in_ready}, '0);
      m_reset();
      #1;
      rst_n = 1'b1;
      #1;
      chk("arst.ready_rise", in_ready, 1'b1);
      step(1, 32'h77, '0, "arst.first");
      chk("arst.first_idx", wr_idx, 3'd0);

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [NSLOT-1:0] r;
         r = NSLOT'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 3) == 0) r = '0;
         step(1'($urandom_range(0, 3) != 0), $urandom, r, $sformatf("rnd%0d", n));
      end

      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL sb.drain: %0d words never reported, expected 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
